// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-channel arbiter between the L1 caches and the single L2 line port
//
// Grants one L1 channel at a time, registers its address/op/wdata towards L2,
// and routes the L2 completion and read line back to that channel only.
// One transaction is outstanding at a time.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined: round-robin search starting after the last winner
//                       undefined: fixed priority, lowest channel index wins
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_read / req_write    per-channel level requests, held until req_resp
//   req_addr / req_wdata    per-channel packed address / write line
//   req_resp                one-cycle completion pulse to the granted channel
//   req_rdata               registered read line, valid with req_resp
//   mem_read / mem_write    registered L2 strobes
//   mem_addr / mem_wdata    registered L2 address / write line
//   mem_resp / mem_rdata    L2 completion and read line
//   grant_id                owner of the current or most recent transaction
//   busy                    high whenever not idle
module mem_port_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req_read,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LINE_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        req_resp,
    output logic [LINE_W-1:0]        req_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic                     mem_resp,
    input  logic [LINE_W-1:0]        mem_rdata,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t state;

    logic [NUM_CH-1:0] req_any;
    logic              found;
    logic [ID_W-1:0]   winner;
    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [LINE_W-1:0] win_wdata;
    logic [NUM_CH-1:0] resp_onehot;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_ptr;
`endif

    assign req_any = req_read | req_write;

    // Winner search. The winner's op and payload are selected here so that the
    // grant cycle only has to register them.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
`ifdef ARB_ROUND_ROBIN_EN
            c = (int'(rr_ptr) + 1 + k) % NUM_CH;
`else
            c = k;
`endif
            if (!found && req_any[c]) begin
                found     = 1'b1;
                winner    = ID_W'(c);
                // A write pending alongside a read goes first; the read is
                // picked up later as a fresh request.
                win_write = req_write[c];
                win_addr  = req_addr[c*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[c*LINE_W +: LINE_W];
            end
        end
    end

    always_comb begin
        resp_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            resp_onehot[i] = (int'(grant_id) == i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            grant_id  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_resp  <= '0;
            req_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= ID_W'(NUM_CH - 1);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        mem_write <= win_write;
                        mem_read  <= !win_write;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr    <= winner;
`endif
                    end
                end
                ST_ISSUE: begin
                    // Request inputs are not looked at here: a requester that
                    // drops out still gets its completion pulse.
                    if (mem_resp) begin
                        req_rdata <= mem_rdata;
                        req_resp  <= resp_onehot;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The owner still holds its request this cycle, so no
                    // arbitration happens until we are back in IDLE.
                    req_resp <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int ID_W   = 1;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic [NUM_CH-1:0]        req_read = '0;
    logic [NUM_CH-1:0]        req_write = '0;
    logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
    logic [NUM_CH*LINE_W-1:0] req_wdata = '0;
    logic [NUM_CH-1:0]        req_resp;
    logic [LINE_W-1:0]        req_rdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic                     mem_resp = 1'b0;
    logic [LINE_W-1:0]        mem_rdata = '0;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    int total = 0;
    int bad   = 0;
    logic auto_resp = 1'b0;

    mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_resp  (req_resp),
        .req_rdata (req_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 = no transaction, 1 = transaction waiting for L2, 2 = completion cycle
    int                m_phase;
    int                m_owner;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    int                m_last;
`endif

    function automatic int first_ch();
`ifdef ARB_ROUND_ROBIN_EN
        return (m_last + 1) % NUM_CH;
`else
        return 0;
`endif
    endfunction

    function automatic int pick(input logic [NUM_CH-1:0] m, input int start);
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int win();
        return pick(req_read | req_write, first_ch());
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input int i);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_owner <= 0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last  <= NUM_CH - 1;
`endif
        end else if (m_phase == 0) begin
            if (win() >= 0) begin
                m_owner <= win();
                m_wr    <= req_write[win()];
                m_addr  <= req_addr[win()*ADDR_W +: ADDR_W];
                m_wdata <= req_wdata[win()*LINE_W +: LINE_W];
                m_phase <= 1;
`ifdef ARB_ROUND_ROBIN_EN
                m_last  <= win();
`endif
            end
        end else if (m_phase == 1) begin
            if (mem_resp) begin
                m_rdata <= mem_rdata;
                m_phase <= 2;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // Single compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        check("busy", busy, m_phase != 0);
        check("mem_read", mem_read, m_phase == 1 && !m_wr);
        check("mem_write", mem_write, m_phase == 1 && m_wr);
        check("grant_id", grant_id, m_owner);
        check("req_resp", req_resp, (m_phase == 2) ? onehot(m_owner) : '0);
        if (m_phase == 1) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        if (m_phase == 2 && !m_wr) check("req_rdata", req_rdata, m_rdata);
        if (!reset_n) begin
            check("rst_addr", mem_addr, '0);
            check("rst_wdata", mem_wdata, '0);
            check("rst_rdata", req_rdata, '0);
        end
    end

    // ---------------- L2 responder (random phase) ----------------
    int wait_cnt = 0;
    initial forever begin
        @(negedge clk);
        #1;
        if (auto_resp) begin
            mem_resp = 1'b0;
            if (mem_read || mem_write) begin
                if (wait_cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    wait_cnt  = $urandom_range(0, 5);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string name);
        for (int c = 0; c < 20 && !(mem_read || mem_write); c++) step();
        check({name, "_strobe_timeout"}, mem_read || mem_write, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 40 && busy; c++) step();
        check({name, "_idle_timeout"}, busy, 1'b0);
    endtask

    int gid[4];
    int exp_gid[4];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_gid = '{0, 1, 0, 1};
`else
        exp_gid = '{0, 0, 0, 0};
`endif
        // 1. reset with both channels requesting
        reset_n = 1'b0;
        req_read = 2'b11;
        req_addr = {16'h0200, 16'h0100};
        repeat (3) step();
        check("t1_rst_read", mem_read, 1'b0);
        check("t1_rst_busy", busy, 1'b0);
        check("t1_rst_resp", req_resp, 2'b00);
        check("t1_rst_gid", grant_id, 0);
        reset_n = 1'b1;
        step();
        check("t1_mem_read", mem_read, 1'b1);
        check("t1_mem_addr", mem_addr, 16'h0100);
        check("t1_gid", grant_id, 0);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check("t1_resp", req_resp, 2'b01);
        req_read = 2'b00;
        wait_idle("t1");

        // 2. single read on ch1, L2 answers after 5 cycles
        req_read = 2'b10;
        req_addr = {16'h1230, 16'h0000};
        step();
        check("t2_gid", grant_id, 1);
        check("t2_addr", mem_addr, 16'h1230);
        repeat (4) step();
        check("t2_held", mem_read, 1'b1);
        mem_resp  = 1'b1;
        mem_rdata = {16{8'hA5}};
        step();
        mem_resp = 1'b0;
        check("t2_resp", req_resp, 2'b10);
        check("t2_rdata", req_rdata, {16{8'hA5}});
        req_read = 2'b00;
        step();
        check("t2_resp_once", req_resp, 2'b00);
        wait_idle("t2");

        // 3. write on ch1
        req_write = 2'b10;
        req_addr  = {16'h0040, 16'h0000};
        req_wdata = {128'h1, 128'h0};
        step();
        req_addr = '1;
        repeat (3) begin
            check("t3_write", mem_write, 1'b1);
            check("t3_read", mem_read, 1'b0);
            check("t3_addr", mem_addr, 16'h0040);
            check("t3_wdata", mem_wdata, 128'h1);
            step();
        end
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check("t3_write_drop", mem_write, 1'b0);
        check("t3_resp", req_resp, 2'b10);
        req_write = 2'b00;
        wait_idle("t3");

        // 4. contention, both channels always requesting
        req_read = 2'b11;
        req_addr = {16'h0b0b, 16'h0a0a};
        for (int t = 0; t < 4; t++) begin
            wait_strobe("t4");
            gid[t] = int'(grant_id);
            mem_resp = 1'b1;
            step();
            mem_resp = 1'b0;
        end
        req_read = 2'b00;
        for (int t = 0; t < 4; t++) check($sformatf("t4_order%0d", t), gid[t], exp_gid[t]);
        wait_idle("t4");

        // 5. reset while the transaction is outstanding
        req_read = 2'b01;
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("t5_async_read", mem_read, 1'b0);
        check("t5_async_busy", busy, 1'b0);
        req_read = 2'b00;
        step();
        reset_n = 1'b1;
        step();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check("t5_no_resp", req_resp, 2'b00);
        step();
        check("t5_no_resp2", req_resp, 2'b00);
        check("t5_idle", busy, 1'b0);

        // 6. request dropped mid-transaction, then a spurious idle mem_resp
        req_read = 2'b01;
        step();
        req_read = 2'b00;
        step();
        step();
        mem_resp  = 1'b1;
        mem_rdata = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        step();
        mem_resp = 1'b0;
        check("t6_resp", req_resp, 2'b01);
        check("t6_rdata", req_rdata, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        step();
        check("t6_resp_once", req_resp, 2'b00);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check("t6_spur_busy", busy, 1'b0);
        check("t6_spur_read", mem_read, 1'b0);
        step();
        check("t6_spur_resp", req_resp, 2'b00);

        // random traffic against the model
        auto_resp = 1'b1;
        repeat (3000) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                #1;
                check("rnd_async_read", mem_read, 1'b0);
                check("rnd_async_write", mem_write, 1'b0);
                step();
                step();
                reset_n = 1'b1;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                int unsigned r;
                r = $urandom_range(1, 3);
                if (req_resp[ch]) begin
                    if (req_write[ch]) req_write[ch] = 1'b0;
                    else req_read[ch] = 1'b0;
                end else if (!req_read[ch] && !req_write[ch]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_read[ch]  = r[0];
                        req_write[ch] = r[1];
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_read[ch]  = 1'b0;
                    req_write[ch] = 1'b0;
                end
                if ($urandom_range(0, 4) == 0) begin
                    req_addr[ch*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
                    req_wdata[ch*LINE_W +: LINE_W] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        req_read  = '0;
        req_write = '0;
        wait_idle("rnd_end");
        auto_resp = 1'b0;
        #1;
        mem_resp = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
